// File: rtl/forwarding_scoreboard.sv
`default_nettype none
// ---------------------------------------------------------------------------
// forwarding_scoreboard : ID-stage forward-select and load-use stall unit
// Rev 1.0
// ---------------------------------------------------------------------------
module forwarding_scoreboard #(
   parameter int NUM_SRC   = 2,
   parameter int FWD_DEPTH = 2,
   parameter int LOAD_LAT  = 2,
   parameter int SEL_W     = $clog2(FWD_DEPTH + 1),
   parameter int CNT_W     = 16
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       id_valid,
   input  logic [NUM_SRC*5-1:0]       id_rs,
   input  logic [4:0]                 id_rd,
   input  logic                       id_reg_write,
   input  logic                       id_is_load,
   input  logic                       flush,
   input  logic                       hold,
   output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
   output logic                       stall,
   output logic [CNT_W-1:0]           stall_count
);

   // Index 0 of every tracker vector is stage 1 (EX).
   logic [FWD_DEPTH-1:0]      valid_q, valid_d;
   logic [FWD_DEPTH-1:0]      wr_q,    wr_d;
   logic [FWD_DEPTH-1:0]      ld_q,    ld_d;
   logic [FWD_DEPTH-1:0][4:0] rd_q,    rd_d;
   logic [CNT_W-1:0]          stall_count_q, stall_count_d;

   logic [NUM_SRC-1:0]        hazard;
   logic                      issue;

   // Oldest stage is scanned first so the youngest match overwrites it.
   always_comb begin
      fwd_sel = '0;
      hazard  = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (valid_q[k] && wr_q[k] && (rd_q[k] != 5'd0) &&
                (rd_q[k] == id_rs[5*s +: 5])) begin
               fwd_sel[s*SEL_W +: SEL_W] = SEL_W'(k + 1);
               hazard[s]                 = ld_q[k] && ((k + 1) < LOAD_LAT);
            end
         end
      end
   end

   assign stall       = id_valid && (|hazard) && !flush;
   assign issue       = id_valid && !stall && !flush;
   assign stall_count = stall_count_q;

   always_comb begin
      valid_d       = valid_q;
      wr_d          = wr_q;
      ld_d          = ld_q;
      rd_d          = rd_q;
      stall_count_d = stall_count_q;
      if (!hold) begin
         for (int k = FWD_DEPTH - 1; k > 0; k--) begin
            valid_d[k] = valid_q[k-1];
            wr_d[k]    = wr_q[k-1];
            ld_d[k]    = ld_q[k-1];
            rd_d[k]    = rd_q[k-1];
         end
         valid_d[0] = issue;
         wr_d[0]    = issue && id_reg_write;
         ld_d[0]    = issue && id_is_load;
         rd_d[0]    = issue ? id_rd : 5'd0;
         if (stall && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         valid_q       <= '0;
         wr_q          <= '0;
         ld_q          <= '0;
         rd_q          <= '0;
         stall_count_q <= '0;
      end else begin
         valid_q       <= valid_d;
         wr_q          <= wr_d;
         ld_q          <= ld_d;
         rd_q          <= rd_d;
         stall_count_q <= stall_count_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_forwarding_scoreboard.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_forwarding_scoreboard : vector table plus hand sequences, three configs
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_forwarding_scoreboard;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       id_valid;
   logic [9:0] id_rs;
   logic [4:0] id_rd;
   logic       id_reg_write;
   logic       id_is_load;
   logic       flush;
   logic       hold;

   logic [3:0]  sel_a;
   logic        stall_a;
   logic [15:0] cnt_a;
   logic [5:0]  sel_b;
   logic        stall_b;
   logic [15:0] cnt_b;
   logic [3:0]  sel_c;
   logic        stall_c;
   logic [1:0]  cnt_c;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // A: default params; B: deep tracker with late load data; C: narrow counter.
   forwarding_scoreboard u_dut_a (
      .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs),
      .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
      .flush(flush), .hold(hold), .fwd_sel(sel_a), .stall(stall_a),
      .stall_count(cnt_a));

   forwarding_scoreboard #(.FWD_DEPTH(4), .LOAD_LAT(3)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs),
      .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
      .flush(flush), .hold(hold), .fwd_sel(sel_b), .stall(stall_b),
      .stall_count(cnt_b));

   forwarding_scoreboard #(.CNT_W(2)) u_dut_c (
      .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs),
      .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
      .flush(flush), .hold(hold), .fwd_sel(sel_c), .stall(stall_c),
      .stall_count(cnt_c));

   typedef struct {
      logic        valid;
      logic [4:0]  rs0, rs1, rd;
      logic        wr, ld, fl, hd;
      logic [1:0]  e0, e1;
      logic        estall;
      logic [15:0] ecnt;
      string       name;
   } vec_t;

   typedef struct {
      int          dut;
      logic [7:0]  sel;
      logic        stall;
      logic [15:0] cnt;
      string       name;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[25];

   function automatic vec_t mk(input logic v, input logic [4:0] a, input logic [4:0] b,
                               input logic [4:0] rd, input logic wr, input logic ld,
                               input logic fl, input logic hd, input logic [1:0] e0,
                               input logic [1:0] e1, input logic es, input logic [15:0] ec,
                               input string nm);
      vec_t r;
      r.valid = v; r.rs0 = a; r.rs1 = b; r.rd = rd; r.wr = wr; r.ld = ld;
      r.fl = fl; r.hd = hd; r.e0 = e0; r.e1 = e1; r.estall = es; r.ecnt = ec;
      r.name = nm;
      return r;
   endfunction

   task automatic drive(input logic v, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] rd, input logic wr, input logic ld,
                        input logic fl, input logic hd);
      id_valid = v; id_rs = {b, a}; id_rd = rd; id_reg_write = wr;
      id_is_load = ld; flush = fl; hold = hd;
   endtask

   task automatic expect_out(input int dut, input logic [7:0] sel, input logic st,
                             input logic [15:0] cnt, input string nm);
      exp_t e;
      e.dut = dut; e.sel = sel; e.stall = st; e.cnt = cnt; e.name = nm;
      sb.push_back(e);
   endtask

   task automatic pop_check();
      exp_t        e;
      logic [7:0]  a_sel;
      logic        a_st;
      logic [15:0] a_cnt;
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("FAIL scoreboard_empty: no expectation queued");
         return;
      end
      e = sb.pop_front();
      case (e.dut)
         0:       begin a_sel = {4'd0, sel_a}; a_st = stall_a; a_cnt = cnt_a; end
         1:       begin a_sel = {2'd0, sel_b}; a_st = stall_b; a_cnt = cnt_b; end
         default: begin a_sel = {4'd0, sel_c}; a_st = stall_c; a_cnt = {14'd0, cnt_c}; end
      endcase
      checks++;
      if (a_sel !== e.sel) begin
         errors++;
         $display("FAIL %s fwd_sel: got %0h expected %0h", e.name, a_sel, e.sel);
      end
      checks++;
      if (a_st !== e.stall) begin
         errors++;
         $display("FAIL %s stall: got %0b expected %0b", e.name, a_st, e.stall);
      end
      checks++;
      if (a_cnt !== e.cnt) begin
         errors++;
         $display("FAIL %s stall_count: got %0d expected %0d", e.name, a_cnt, e.cnt);
      end
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are checked at the falling edge.
   task automatic sample_and_advance();
      @(negedge clk);
      pop_check();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;

      tbl[0]  = mk(0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");
      tbl[1]  = mk(1, 1, 2,   5, 1, 0, 0, 0, 0, 0, 0, 0, "add_x5");
      tbl[2]  = mk(1, 5, 0,  10, 1, 0, 0, 0, 1, 0, 0, 0, "fwd_stage1");
      tbl[3]  = mk(1, 5, 0,   0, 0, 0, 0, 0, 2, 0, 0, 0, "fwd_stage2");
      tbl[4]  = mk(0, 5, 10,  0, 0, 0, 0, 0, 0, 2, 0, 0, "aged_out");
      tbl[5]  = mk(1, 0, 0,   7, 1, 1, 0, 0, 0, 0, 0, 0, "lw_x7");
      tbl[6]  = mk(1, 0, 7,   8, 1, 0, 0, 0, 0, 1, 1, 0, "load_use");
      tbl[7]  = mk(1, 0, 7,   8, 1, 0, 0, 0, 0, 2, 0, 1, "load_fwd");
      tbl[8]  = mk(1, 8, 0,   3, 1, 0, 0, 0, 1, 0, 0, 1, "wr_x3_a");
      tbl[9]  = mk(1, 3, 3,   3, 1, 0, 0, 0, 1, 1, 0, 1, "wr_x3_b");
      tbl[10] = mk(1, 3, 3,   0, 1, 0, 0, 0, 1, 1, 0, 1, "youngest_wins");
      tbl[11] = mk(0, 0, 3,   0, 0, 0, 0, 0, 0, 2, 0, 1, "rd_x0");
      tbl[12] = mk(1, 0, 0,   4, 1, 1, 0, 0, 0, 0, 0, 1, "lw_x4");
      tbl[13] = mk(1, 4, 0,   9, 1, 0, 1, 0, 1, 0, 0, 1, "flush_hazard");
      tbl[14] = mk(0, 9, 4,   0, 0, 0, 0, 0, 0, 2, 0, 1, "flushed_bubble");
      tbl[15] = mk(1, 0, 0,  11, 1, 0, 0, 0, 0, 0, 0, 1, "add_x11");
      tbl[16] = mk(0, 11, 0,  0, 0, 0, 0, 1, 1, 0, 0, 1, "hold_1");
      tbl[17] = mk(0, 11, 0,  0, 0, 0, 0, 1, 1, 0, 0, 1, "hold_2");
      tbl[18] = mk(0, 11, 0,  0, 0, 0, 0, 1, 1, 0, 0, 1, "hold_3");
      tbl[19] = mk(0, 11, 0,  0, 0, 0, 0, 0, 1, 0, 0, 1, "hold_release");
      tbl[20] = mk(0, 11, 0,  0, 0, 0, 0, 0, 2, 0, 0, 1, "after_hold");
      tbl[21] = mk(1, 0, 0,  12, 1, 1, 0, 0, 0, 0, 0, 1, "lw_x12");
      tbl[22] = mk(1, 12, 12, 13, 1, 0, 0, 1, 1, 1, 1, 1, "stall_under_hold");
      tbl[23] = mk(1, 12, 12, 13, 1, 0, 0, 0, 1, 1, 1, 1, "stall_released");
      tbl[24] = mk(1, 12, 12, 13, 1, 0, 0, 0, 2, 2, 0, 2, "load_fwd2");

      // Reset state seen with live register indices on the ID bus.
      drive(1, 5, 7, 0, 0, 0, 0, 0);
      expect_out(0, 8'h00, 1'b0, 16'd0, "reset_a");
      expect_out(1, 8'h00, 1'b0, 16'd0, "reset_b");
      expect_out(2, 8'h00, 1'b0, 16'd0, "reset_c");
      @(negedge clk);
      pop_check(); pop_check(); pop_check();
      @(posedge clk);
      #1;
      do_reset();

      for (int i = 0; i < 25; i++) begin
         drive(tbl[i].valid, tbl[i].rs0, tbl[i].rs1, tbl[i].rd, tbl[i].wr,
               tbl[i].ld, tbl[i].fl, tbl[i].hd);
         expect_out(0, {4'd0, tbl[i].e1, tbl[i].e0}, tbl[i].estall, tbl[i].ecnt, tbl[i].name);
         sample_and_advance();
      end

      // Deep tracker: load needs two stall cycles, one extra frozen by hold.
      do_reset();
      drive(1, 0, 0, 9, 1, 1, 0, 0);
      expect_out(1, 8'd0, 1'b0, 16'd0, "deep_lw_x9");
      sample_and_advance();
      drive(1, 9, 0, 13, 1, 0, 0, 0);
      expect_out(1, 8'd1, 1'b1, 16'd0, "deep_stall1");
      sample_and_advance();
      drive(1, 9, 0, 13, 1, 0, 0, 1);
      expect_out(1, 8'd2, 1'b1, 16'd1, "deep_hold");
      sample_and_advance();
      drive(1, 9, 0, 13, 1, 0, 0, 0);
      expect_out(1, 8'd2, 1'b1, 16'd1, "deep_stall2");
      sample_and_advance();
      expect_out(1, 8'd3, 1'b0, 16'd2, "deep_fwd3");
      sample_and_advance();

      // Self-dependent load stream: stalls every other cycle, counter saturates.
      do_reset();
      drive(1, 7, 0, 7, 1, 1, 0, 0);
      for (int i = 0; i < 12; i++) begin
         logic [7:0]  esel;
         logic [15:0] ecnt;
         esel = (i == 0) ? 8'd0 : ((i % 2 == 1) ? 8'd1 : 8'd2);
         ecnt = (i / 2 > 3) ? 16'd3 : 16'(i / 2);
         expect_out(2, esel, (i % 2 == 1), ecnt, "sat_stream");
         if (i == 11) reset_n = 1'b0;
         sample_and_advance();
      end
      reset_n = 1'b1;
      expect_out(2, 8'd0, 1'b0, 16'd0, "reset_mid_stall");
      sample_and_advance();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: timeout reached, expected completion");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
